// File: rtl/proc_run_pkg.sv
// Shared types for the processor run controller: FSM state encoding
// and the writeback trace record layout.
package proc_run_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        DONE,
        TIMEOUT
    } run_state_t;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
    } trace_rec_t;

endpackage

// File: rtl/trace_ring_buf.sv
// Ring buffer holding the most recent DEPTH writeback records.
// Readback is addressed relative to the newest entry (index 0 = newest).
module trace_ring_buf
    import proc_run_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [$clog2(DEPTH):0]     fill,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]           rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      fill_q;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Write pointer wraps naturally; fill count saturates once the ring is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            fill_q <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            fill_q <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill_q != FULL) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset; the fill count masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_addr = wr_ptr - 1'b1 - rd_idx;
    assign rd_data = ({1'b0, rd_idx} < fill_q) ? mem[rd_addr] : '0;
    assign fill    = fill_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller for the Processor core: sequences core reset, watches
// halt with a cycle-budget watchdog, gathers run statistics and keeps a
// trace of the most recent writebacks for post-mortem readback.
module proc_run_ctrl
    import proc_run_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TRACE_DEPTH    = 16,
    parameter int CNT_W          = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           proc_rst,
    input  logic                           halt,
    input  logic                           trace_valid,
    input  logic [XLEN-1:0]                trace_pc,
    input  logic [XLEN-1:0]                trace_inst,
    output logic                           busy,
    output logic                           done,
    output logic                           timed_out,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CNT_W-1:0]               retire_count,
    output logic [$clog2(TRACE_DEPTH):0]   trace_fill,
    input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]                rd_pc,
    output logic [XLEN-1:0]                rd_inst
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);

    run_state_t        state_q;
    run_state_t        state_d;
    logic              launch;
    logic              in_run;
    logic [RC_W-1:0]   rst_cnt;
    logic [2*XLEN-1:0] rd_rec;

    // Next-state selection; halt takes priority over an expiring budget.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (start) state_d = RESET;
            RESET:         if (rst_cnt == '0) state_d = RUN;
            RUN: begin
                if (halt) begin
                    state_d = DONE;
                end else if (TO_EN && (cycle_count == TO_LAST)) begin
                    state_d = TIMEOUT;
                end
            end
            DONE, TIMEOUT: if (start) state_d = RESET;
            default:       state_d = IDLE;
        endcase
    end

    assign launch    = (state_q != RESET) && (state_d == RESET);
    assign in_run    = (state_q == RUN);
    assign proc_rst  = (state_q inside {IDLE, RESET, TIMEOUT});
    assign busy      = (state_q inside {RESET, RUN});
    assign done      = (state_q == DONE);
    assign timed_out = (state_q == TIMEOUT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset-phase down-counter, loaded on every launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt <= '0;
        end else if (launch) begin
            rst_cnt <= RC_LOAD;
        end else if ((state_q == RESET) && (rst_cnt != '0)) begin
            rst_cnt <= rst_cnt - 1'b1;
        end
    end

    // Saturating run statistics, cleared at the start of each launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count  <= '0;
            retire_count <= '0;
        end else if (launch) begin
            cycle_count  <= '0;
            retire_count <= '0;
        end else if (in_run) begin
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (trace_valid && (retire_count != '1)) begin
                retire_count <= retire_count + 1'b1;
            end
        end
    end

    trace_ring_buf #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (2*XLEN)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (launch),
        .wr_en   (in_run && trace_valid),
        .wr_data ({trace_pc, trace_inst}),
        .fill    (trace_fill),
        .rd_idx  (rd_idx),
        .rd_data (rd_rec)
    );

    assign {rd_pc, rd_inst} = rd_rec;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: the stimulus process queues the
// expected end-of-run picture, and a monitor checks it when the run ends.
module tb_proc_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        proc_rst;
    logic        halt;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_inst;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;
    logic [2:0]  trace_fill;
    logic [1:0]  rd_idx;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic            exp_done;
        logic            exp_to;
        logic            exp_prst;
        logic [31:0]     cyc;
        logic [31:0]     ret;
        logic [2:0]      fill;
        logic [3:0][31:0] pc;
        logic [3:0][31:0] inst;
    } exp_t;

    exp_t sb_q[$];

    proc_run_ctrl #(
        .XLEN           (32),
        .RESET_CYCLES   (2),
        .TIMEOUT_CYCLES (50),
        .TRACE_DEPTH    (4),
        .CNT_W          (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .proc_rst     (proc_rst),
        .halt         (halt),
        .trace_valid  (trace_valid),
        .trace_pc     (trace_pc),
        .trace_inst   (trace_inst),
        .busy         (busy),
        .done         (done),
        .timed_out    (timed_out),
        .cycle_count  (cycle_count),
        .retire_count (retire_count),
        .trace_fill   (trace_fill),
        .rd_idx       (rd_idx),
        .rd_pc        (rd_pc),
        .rd_inst      (rd_inst)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got=running required=finished");
        $fatal(1, "[TB] simulation time limit hit");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic h, input logic tv,
                                 input logic [31:0] pc, input logic [31:0] inst);
        start       = s;
        halt        = h;
        trace_valid = tv;
        trace_pc    = pc;
        trace_inst  = inst;
    endtask

    // Start a run from the current negedge and walk through both reset cycles.
    task automatic launchRun(input logic noisy);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("rst1_proc_rst", 32'(proc_rst), 32'd1);
        checkOutput("rst1_busy", 32'(busy), 32'd1);
        checkOutput("rst1_cycle_clr", cycle_count, 32'd0);
        checkOutput("rst1_retire_clr", retire_count, 32'd0);
        checkOutput("rst1_fill_clr", 32'(trace_fill), 32'd0);
        applyStimulus(1'b0, noisy, noisy, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("rst2_proc_rst", 32'(proc_rst), 32'd1);
        checkOutput("rst2_done", 32'(done), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("run1_proc_rst", 32'(proc_rst), 32'd0);
        checkOutput("run1_busy", 32'(busy), 32'd1);
        checkOutput("run1_done", 32'(done), 32'd0);
        checkOutput("run1_retire", retire_count, 32'd0);
        checkOutput("run1_fill", 32'(trace_fill), 32'd0);
    endtask

    // Drive RUN cycles until the run ends or the budget expires.
    // mode 0: retire on cycles 2,4,6 (pc 0x100+4i), stray start on cycle 3
    // mode 1: retire on cycles 1..6 (pc 0x10,0x14,...)
    // mode 2: no retirements
    task automatic runCycles(input int halt_at, input int mode, input int budget, output int ran);
        logic        tv;
        logic [31:0] pc;
        logic [31:0] inst;
        ran = 0;
        while (!(done || timed_out) && ran < budget) begin
            ran++;
            tv   = 1'b0;
            pc   = 32'h0;
            inst = 32'h0;
            if (mode == 0) begin
                tv   = (ran == 2) || (ran == 4) || (ran == 6);
                pc   = 32'h100 + 32'(4 * ran);
                inst = 32'hA000_0000 + 32'(ran);
            end else if (mode == 1) begin
                tv   = (ran <= 6);
                pc   = 32'h10 + 32'(4 * (ran - 1));
                inst = 32'hB000_0000 + 32'(ran);
            end
            applyStimulus((mode == 0) && (ran == 3), (ran == halt_at), tv, pc, inst);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: on each new DONE/TIMEOUT, pop an expectation and compare the
    // status, counters and the whole readback window.
    initial begin
        exp_t e;
        logic seen;
        seen   = 1'b0;
        rd_idx = 2'd0;
        forever begin
            @(negedge clk);
            if (rst_n && (done || timed_out) && !seen) begin
                seen = 1'b1;
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL sb_unexpected_end: got=run_end required=none");
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_done", 32'(done), 32'(e.exp_done));
                    checkOutput("sb_timed_out", 32'(timed_out), 32'(e.exp_to));
                    checkOutput("sb_proc_rst", 32'(proc_rst), 32'(e.exp_prst));
                    checkOutput("sb_busy", 32'(busy), 32'd0);
                    checkOutput("sb_cycle_count", cycle_count, e.cyc);
                    checkOutput("sb_retire_count", retire_count, e.ret);
                    checkOutput("sb_trace_fill", 32'(trace_fill), 32'(e.fill));
                    for (int k = 0; k < 4; k++) begin
                        rd_idx = 2'(k);
                        #1;
                        checkOutput($sformatf("sb_rd_pc%0d", k), rd_pc, e.pc[k]);
                        checkOutput($sformatf("sb_rd_inst%0d", k), rd_inst, e.inst[k]);
                    end
                    rd_idx = 2'd0;
                end
            end else if (!(done || timed_out)) begin
                seen = 1'b0;
            end
        end
    end

    // Directed stimulus.
    initial begin
        exp_t e;
        int   ran;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("por_proc_rst", 32'(proc_rst), 32'd1);
        checkOutput("por_busy", 32'(busy), 32'd0);
        checkOutput("por_done", 32'(done), 32'd0);
        checkOutput("por_timed_out", 32'(timed_out), 32'd0);
        checkOutput("por_cycle", cycle_count, 32'd0);
        checkOutput("por_fill", 32'(trace_fill), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Run 1: halt on RUN cycle 10, retire on 2/4/6, start in RUN ignored,
        // halt/trace_valid during RESET ignored.
        e = '0;
        e.exp_done = 1'b1; e.exp_to = 1'b0; e.exp_prst = 1'b0;
        e.cyc = 32'd10; e.ret = 32'd3; e.fill = 3'd3;
        e.pc[0] = 32'h118; e.pc[1] = 32'h110; e.pc[2] = 32'h108; e.pc[3] = 32'h0;
        e.inst[0] = 32'hA000_0006; e.inst[1] = 32'hA000_0004;
        e.inst[2] = 32'hA000_0002; e.inst[3] = 32'h0;
        sb_q.push_back(e);
        launchRun(1'b1);
        runCycles(10, 0, 60, ran);
        checkOutput("run1_len", 32'(ran), 32'd10);

        // Run 2: relaunch from DONE, no halt, watchdog fires after 50 cycles;
        // six retirements wrap the 4-entry ring.
        e = '0;
        e.exp_done = 1'b0; e.exp_to = 1'b1; e.exp_prst = 1'b1;
        e.cyc = 32'd50; e.ret = 32'd6; e.fill = 3'd4;
        e.pc[0] = 32'h24; e.pc[1] = 32'h20; e.pc[2] = 32'h1C; e.pc[3] = 32'h18;
        e.inst[0] = 32'hB000_0006; e.inst[1] = 32'hB000_0005;
        e.inst[2] = 32'hB000_0004; e.inst[3] = 32'hB000_0003;
        sb_q.push_back(e);
        launchRun(1'b0);
        runCycles(0, 1, 60, ran);
        checkOutput("run2_len", 32'(ran), 32'd50);

        // Run 3: relaunch from TIMEOUT, halt exactly as the budget expires.
        e = '0;
        e.exp_done = 1'b1; e.exp_to = 1'b0; e.exp_prst = 1'b0;
        e.cyc = 32'd50; e.ret = 32'd0; e.fill = 3'd0;
        sb_q.push_back(e);
        launchRun(1'b0);
        runCycles(50, 2, 60, ran);
        checkOutput("run3_len", 32'(ran), 32'd50);

        // Run 4: abort mid-RUN with rst_n, checked between clock edges.
        launchRun(1'b0);
        runCycles(0, 1, 5, ran);
        checkOutput("run4_len", 32'(ran), 32'd5);
        checkOutput("run4_cycle", cycle_count, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_proc_rst", 32'(proc_rst), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_cycle", cycle_count, 32'd0);
        checkOutput("abort_retire", retire_count, 32'd0);
        checkOutput("abort_fill", 32'(trace_fill), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_abort_busy", 32'(busy), 32'd0);
        checkOutput("post_abort_done", 32'(done), 32'd0);

        repeat (2) @(negedge clk);
        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
